// File: rtl/multi_key_debouncer.sv
// multi_key_debouncer
//   N-channel push-button conditioner. Each channel has a 2-FF synchroniser,
//   a counter-based debouncer, a RELEASED/PRESSED/HELD state machine that
//   produces press/release/long-press/auto-repeat pulses, and a modulo-CNT_M
//   event counter advanced by press and repeat events. Single clock domain.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   en            in   event enable (0: pulses forced low, counters hold)
//   key_in        in   [N_CH]        raw asynchronous key inputs
//   key_level     out  [N_CH]        debounced level, 1 = pressed
//   press_pulse   out  [N_CH]        1-cycle pulse on accepted press
//   release_pulse out  [N_CH]        1-cycle pulse on accepted release
//   long_pulse    out  [N_CH]        1-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse  out  [N_CH]        1-cycle pulse every REPEAT_CYCLES while held
//   count         out  [N_CH*CNT_W]  per-channel event counter, ch i at [i*CNT_W +: CNT_W]
`timescale 1ns/1ps
module multi_key_debouncer #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned DEB_CYCLES    = 1_000_000,
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned CNT_M         = 15,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N_CH-1:0]         key_in,
    output logic [N_CH-1:0]         key_level,
    output logic [N_CH-1:0]         press_pulse,
    output logic [N_CH-1:0]         release_pulse,
    output logic [N_CH-1:0]         long_pulse,
    output logic [N_CH-1:0]         repeat_pulse,
    output logic [N_CH*CNT_W-1:0]   count
);

    // Debounce counter only needs to reach DEB_CYCLES-1.
    localparam int unsigned DW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    // One timer serves as hold timer (PRESSED) and repeat timer (HELD).
    localparam int unsigned T_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW    = $clog2(T_MAX);
    localparam int unsigned REP_LAST = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

    localparam logic [DW-1:0]    DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0]    LONG_LAST = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0]    RPT_LAST  = TW'(REP_LAST);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_M - 1);

    if (CNT_M > (1 << CNT_W)) begin : g_bad_cnt_m
        $error("multi_key_debouncer: CNT_M exceeds 2**CNT_W");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("multi_key_debouncer: DEB_CYCLES must be >= 1");
    end
    if (LONG_CYCLES <= DEB_CYCLES) begin : g_bad_long
        $error("multi_key_debouncer: LONG_CYCLES must exceed DEB_CYCLES");
    end

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESSED,
        ST_HELD
    } state_t;

    logic [N_CH-1:0]  r_sync1, r_sync2, r_level;
    logic [N_CH-1:0]  r_press, r_release, r_long, r_repeat;
    logic [DW-1:0]    r_deb_cnt [N_CH];
    logic [TW-1:0]    r_tmr     [N_CH];
    logic [CNT_W-1:0] r_count   [N_CH];
    state_t           r_state   [N_CH];

    logic [N_CH-1:0]  w_p, w_rise, w_fall;
    logic [N_CH-1:0]  w_press, w_release, w_long, w_repeat;
    logic [TW-1:0]    w_tmr_nxt   [N_CH];
    state_t           w_state_nxt [N_CH];

    // Normalised sample and accepted level changes (the edge that toggles r_level).
    always_comb begin
        w_p    = ACTIVE_LOW ? ~r_sync2 : r_sync2;
        w_rise = '0;
        w_fall = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if ((w_p[i] != r_level[i]) && (r_deb_cnt[i] == DEB_LAST)) begin
                w_rise[i] = w_p[i];
                w_fall[i] = ~w_p[i];
            end
        end
    end

    // Per-channel FSM next state, timer and raw (pre-enable) events.
    always_comb begin
        w_press   = '0;
        w_release = '0;
        w_long    = '0;
        w_repeat  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_tmr_nxt[i]   = r_tmr[i];
            case (r_state[i])
                ST_RELEASED: begin
                    if (w_rise[i]) begin
                        w_state_nxt[i] = ST_PRESSED;
                        w_tmr_nxt[i]   = '0;
                        w_press[i]     = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (w_fall[i]) begin
                        w_state_nxt[i] = ST_RELEASED;
                        w_tmr_nxt[i]   = '0;
                        w_release[i]   = 1'b1;
                    end else if (r_tmr[i] == LONG_LAST) begin
                        w_state_nxt[i] = ST_HELD;
                        w_tmr_nxt[i]   = '0;
                        w_long[i]      = 1'b1;
                    end else begin
                        w_tmr_nxt[i]   = r_tmr[i] + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (w_fall[i]) begin
                        w_state_nxt[i] = ST_RELEASED;
                        w_tmr_nxt[i]   = '0;
                        w_release[i]   = 1'b1;
                    end else if (REPEAT_CYCLES > 0) begin
                        if (r_tmr[i] == RPT_LAST) begin
                            w_tmr_nxt[i] = '0;
                            w_repeat[i]  = 1'b1;
                        end else begin
                            w_tmr_nxt[i] = r_tmr[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_RELEASED;
                    w_tmr_nxt[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= {N_CH{ACTIVE_LOW}};
            r_sync2   <= {N_CH{ACTIVE_LOW}};
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_long    <= '0;
            r_repeat  <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_deb_cnt[i] <= '0;
                r_tmr[i]     <= '0;
                r_count[i]   <= '0;
                r_state[i]   <= ST_RELEASED;
            end
        end else begin
            r_sync1   <= key_in;
            r_sync2   <= r_sync1;
            r_press   <= w_press   & {N_CH{en}};
            r_release <= w_release & {N_CH{en}};
            r_long    <= w_long    & {N_CH{en}};
            r_repeat  <= w_repeat  & {N_CH{en}};
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (w_p[i] == r_level[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_deb_cnt[i] <= '0;
                    r_level[i]   <= w_p[i];
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
                r_state[i] <= w_state_nxt[i];
                r_tmr[i]   <= w_tmr_nxt[i];
                // Press and repeat are mutually exclusive, so at most one step per cycle.
                if (en && (w_press[i] || w_repeat[i])) begin
                    r_count[i] <= (r_count[i] == CNT_LAST) ? '0 : r_count[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            count[i*CNT_W +: CNT_W] = r_count[i];
        end
    end

    assign key_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign repeat_pulse  = r_repeat;

endmodule
